frwd_sb: RTL

Parametrised operand forwarding unit with an internal destination-register scoreboard. It sits at the issue/ID-to-EX boundary. It tracks the destination of every in-flight instruction across DEPTH downstream stages, picks the youngest producer for each source operand, and substitutes PC or constant 4 for auipc/jal/jalr. It raises a stall when the youngest producer's result is not yet available (load-use or multi-cycle result), removing the need for hazard-detection select lines from outside.

---
 rtl/frwd_sb_if.sv | 57 +++++
 rtl/frwd_sb.sv | 106 ++++++++++
 2 files changed

// File: rtl/frwd_sb_if.sv
// -----------------------------------------------------------------------------
// frwd_sb_if : issue-side bundle of the forwarding/scoreboard unit.
//   Groups every signal of frwd_sb except clock and reset.
//   master : issue/decode stage and datapath (drives i_*, observes o_*)
//   slave  : frwd_sb itself (observes i_*, drives o_*)
// Port summary (widths by parameter):
//   i_issue_valid/_wen/_rd  issuing instruction and its destination
//   i_rs1/2_addr, _rdata    source addresses and register-file read data
//   i_pc, i_auipc/_jal/_jalr PC and operand-substitution modes
//   i_hold, i_flush          pipeline freeze / squash of issuing instruction
//   i_stg_res, i_stg_rdy     per-stage results and their valid flags
//   o_op1/o_op2/o_jalr_op1   final operands
//   o_stall/o_accept         hazard stall and issue acceptance
//   o_stall_cnt              saturating hazard-stall cycle counter
// -----------------------------------------------------------------------------
interface frwd_sb_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 3,
  parameter int RADDR = 5,
  parameter int CNTW  = 16
);
  logic                    i_issue_valid;
  logic                    i_issue_wen;
  logic [RADDR-1:0]        i_issue_rd;
  logic [RADDR-1:0]        i_rs1_addr;
  logic [RADDR-1:0]        i_rs2_addr;
  logic [XLEN-1:0]         i_rs1_rdata;
  logic [XLEN-1:0]         i_rs2_rdata;
  logic [XLEN-1:0]         i_pc;
  logic                    i_auipc;
  logic                    i_jal;
  logic                    i_jalr;
  logic                    i_hold;
  logic                    i_flush;
  logic [DEPTH*XLEN-1:0]   i_stg_res;
  logic [DEPTH-1:0]        i_stg_rdy;
  logic [XLEN-1:0]         o_op1;
  logic [XLEN-1:0]         o_op2;
  logic [XLEN-1:0]         o_jalr_op1;
  logic                    o_stall;
  logic                    o_accept;
  logic [CNTW-1:0]         o_stall_cnt;

  modport master (
    output i_issue_valid, i_issue_wen, i_issue_rd, i_rs1_addr, i_rs2_addr,
           i_rs1_rdata, i_rs2_rdata, i_pc, i_auipc, i_jal, i_jalr,
           i_hold, i_flush, i_stg_res, i_stg_rdy,
    input  o_op1, o_op2, o_jalr_op1, o_stall, o_accept, o_stall_cnt
  );

  modport slave (
    input  i_issue_valid, i_issue_wen, i_issue_rd, i_rs1_addr, i_rs2_addr,
           i_rs1_rdata, i_rs2_rdata, i_pc, i_auipc, i_jal, i_jalr,
           i_hold, i_flush, i_stg_res, i_stg_rdy,
    output o_op1, o_op2, o_jalr_op1, o_stall, o_accept, o_stall_cnt
  );
endinterface

// File: rtl/frwd_sb.sv
// -----------------------------------------------------------------------------
// frwd_sb : operand forwarding unit with destination-register scoreboard.
//   Sits between issue and EX. Entry k of the scoreboard mirrors downstream
//   stage k (0 = EX). For each source the youngest in-flight producer is
//   selected; if its stage result is not ready the unit stalls issue.
//   auipc replaces op1 with PC, jal/jalr replace op2 with 4.
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-high reset (clears scoreboard and counter)
//   io_bus  frwd_sb_if slave modport carrying all issue/operand signals
// -----------------------------------------------------------------------------
module frwd_sb #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 3,
  parameter int RADDR = 5,
  parameter int CNTW  = 16
) (
  input  logic     i_clk,
  input  logic     i_rst,
  frwd_sb_if.slave io_bus
);

  typedef struct packed {
    logic             vld;
    logic [RADDR-1:0] rd;
  } sb_entry_t;

  localparam logic [XLEN-1:0] LINK_OFS = XLEN'(4);

  sb_entry_t        r_sb [DEPTH];
  logic [CNTW-1:0]  r_stall_cnt;

  logic [XLEN-1:0]  w_rs1_fwd;
  logic [XLEN-1:0]  w_rs2_fwd;
  logic             w_rs1_haz;
  logic             w_rs2_haz;
  logic             w_stall;
  logic             w_accept;
  logic             w_alloc;

  // Walk from oldest to youngest so the youngest match is the last writer
  // and wins; an older ready producer can never mask a younger busy one.
  // x0 never matches, so it always reads the register file.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the loop leaves it unassigned (which would infer a latch).
    w_rs1_fwd = io_bus.i_rs1_rdata;
    w_rs2_fwd = io_bus.i_rs2_rdata;
    w_rs1_haz = 1'b0;
    w_rs2_haz = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (r_sb[k].vld && (r_sb[k].rd == io_bus.i_rs1_addr) &&
          (io_bus.i_rs1_addr != '0)) begin
        w_rs1_fwd = io_bus.i_stg_res[k*XLEN +: XLEN];
        w_rs1_haz = ~io_bus.i_stg_rdy[k];
      end
      if (r_sb[k].vld && (r_sb[k].rd == io_bus.i_rs2_addr) &&
          (io_bus.i_rs2_addr != '0)) begin
        w_rs2_fwd = io_bus.i_stg_res[k*XLEN +: XLEN];
        w_rs2_haz = ~io_bus.i_stg_rdy[k];
      end
    end
  end

  assign w_stall  = io_bus.i_issue_valid & (w_rs1_haz | w_rs2_haz);
  assign w_accept = io_bus.i_issue_valid & ~w_stall & ~io_bus.i_hold &
                    ~io_bus.i_flush;
  // Writes to x0 are never tracked: nothing can depend on them.
  assign w_alloc  = w_accept & io_bus.i_issue_wen & (io_bus.i_issue_rd != '0);

  assign io_bus.o_jalr_op1  = w_rs1_fwd;
  assign io_bus.o_op1       = io_bus.i_auipc ? io_bus.i_pc : w_rs1_fwd;
  assign io_bus.o_op2       = (io_bus.i_jal | io_bus.i_jalr) ? LINK_OFS : w_rs2_fwd;
  assign io_bus.o_stall     = w_stall;
  assign io_bus.o_accept    = w_accept;
  assign io_bus.o_stall_cnt = r_stall_cnt;

  // Scoreboard shifts with the pipeline; a held pipeline keeps every entry,
  // except that a flush during hold kills the instruction sitting in EX.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the scoreboard is a few flops, not a RAM, so every entry is
      // cleared on reset; a stale vld would forward garbage after reset.
      for (int k = 0; k < DEPTH; k++) begin
        r_sb[k] <= '0;
      end
      r_stall_cnt <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so the shift
      // below reads the pre-edge value of r_sb[k-1] for every k.
      if (!io_bus.i_hold) begin
        for (int k = 1; k < DEPTH; k++) begin
          r_sb[k] <= r_sb[k-1];
        end
        r_sb[0] <= '{vld: w_alloc, rd: io_bus.i_issue_rd};
      end else if (io_bus.i_flush) begin
        r_sb[0].vld <= 1'b0;
      end

      if (w_stall && !io_bus.i_hold && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

endmodule
